// File: rtl/toggle_mon_pkg.sv
// Shared types and helpers for the toggle activity monitor.
package toggle_mon_pkg;

  localparam int WIN_IDX_W = 8;

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  // Width-independent part of an output record; the count fields are
  // sized by the instantiating module and wrap around this header.
  typedef struct packed {
    logic [WIN_IDX_W-1:0] win_idx;
    logic                 partial;
    logic                 sat;
  } rec_hdr_t;

  // Saturating add of two w-bit quantities (w <= 31).
  // Bit 32 flags that the true sum exceeded 2^w-1; bits [31:0] hold the clamped result.
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int w);
    logic [32:0] s;
    logic [32:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (33'd1 << w) - 33'd1;
    if (s > mx) return {1'b1, mx[31:0]};
    return {1'b0, s[31:0]};
  endfunction

endpackage

// File: rtl/toggle_activity_monitor_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module popcount #(
  parameter int WIDTH = 3,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CW-1:0]    cnt
);

  // Sum the set bits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) cnt = cnt + CW'(vec[i]);
  end

endmodule

// File: rtl/toggle_activity_monitor.sv
// Toggle activity monitor: counts bit toggles on sig per WINDOW-cycle window
// and emits one record per window over valid/ready.
// Optional: define TOGGLE_ACTIVITY_DUTY_EN to add out_ones, the per-window
// sum of popcount(sig) over counted cycles.
module toggle_activity_monitor
  import toggle_mon_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     sig,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     out_toggles,
  output logic [WIN_IDX_W-1:0] out_win_idx,
  output logic                 out_partial,
  output logic                 out_sat,
  output logic [7:0]           drop_cnt
`ifdef TOGGLE_ACTIVITY_DUTY_EN
  ,
  output logic [CNT_W+4-1:0]   out_ones
`endif
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int CYC_W = $clog2(WINDOW);
`ifdef TOGGLE_ACTIVITY_DUTY_EN
  localparam int ONES_W = CNT_W + 4;
`endif

  typedef struct packed {
    logic [CNT_W-1:0]  toggles;
    rec_hdr_t          hdr;
`ifdef TOGGLE_ACTIVITY_DUTY_EN
    logic [ONES_W-1:0] ones;
`endif
  } rec_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     prev;
  logic [CNT_W-1:0]     acc, acc_nxt;
  logic                 sat, acc_hit;
  logic [CYC_W-1:0]     cyc;
  logic [WIN_IDX_W-1:0] win_idx;
  rec_t                 out_rec, rec_close;
  logic                 cap, cnt_en, close, part, clr;
  logic [PC_W-1:0]      pc_tog;
  logic [32:0]          acc_sa;
  logic                 acc_unused;

  popcount #(.WIDTH(WIDTH), .CW(PC_W)) u_pc_tog (.vec(sig ^ prev), .cnt(pc_tog));

  assign acc_sa     = sat_add(32'(acc), 32'(pc_tog), CNT_W);
  assign acc_nxt    = acc_sa[CNT_W-1:0];
  assign acc_hit    = acc_sa[32];
  assign acc_unused = &{1'b0, acc_sa[31:CNT_W]};

`ifdef TOGGLE_ACTIVITY_DUTY_EN
  logic [ONES_W-1:0] ones_acc, ones_nxt;
  logic [PC_W-1:0]   pc_ones;
  logic [32:0]       ones_sa;
  logic              ones_unused;

  popcount #(.WIDTH(WIDTH), .CW(PC_W)) u_pc_ones (.vec(sig), .cnt(pc_ones));

  assign ones_sa     = sat_add(32'(ones_acc), 32'(pc_ones), ONES_W);
  assign ones_nxt    = ones_sa[ONES_W-1:0];
  assign ones_unused = &{1'b0, ones_sa[32:ONES_W]};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle datapath controls.
  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    cnt_en    = 1'b0;
    close     = 1'b0;
    part      = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: if (en) begin
        cap       = 1'b1;
        state_nxt = ARM;
      end
      ARM: if (en) begin
        cap       = 1'b1;
        clr       = 1'b1;
        state_nxt = RUN;
      end else begin
        state_nxt = IDLE;
      end
      RUN: if (en) begin
        cnt_en = 1'b1;
        if (cyc == CYC_W'(WINDOW - 1)) begin
          close = 1'b1;
          clr   = 1'b1;
        end
      end else begin
        // Falling en ends the window; this cycle is not counted.
        close     = (cyc != '0);
        part      = 1'b1;
        clr       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Record contents at close: a full window includes the current cycle, a partial one does not.
  always_comb begin
    rec_close             = '0;
    rec_close.toggles     = cnt_en ? acc_nxt : acc;
    rec_close.hdr.win_idx = win_idx;
    rec_close.hdr.partial = part;
    rec_close.hdr.sat     = cnt_en ? (sat | acc_hit) : sat;
`ifdef TOGGLE_ACTIVITY_DUTY_EN
    rec_close.ones        = cnt_en ? ones_nxt : ones_acc;
`endif
  end

  // Accumulators, window counter, output register and drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev      <= '0;
      acc       <= '0;
      sat       <= 1'b0;
      cyc       <= '0;
      win_idx   <= '0;
      out_rec   <= '0;
      out_valid <= 1'b0;
      drop_cnt  <= '0;
`ifdef TOGGLE_ACTIVITY_DUTY_EN
      ones_acc  <= '0;
`endif
    end else begin
      if (cap || cnt_en) prev <= sig;
      if (clr) begin
        acc      <= '0;
        sat      <= 1'b0;
        cyc      <= '0;
`ifdef TOGGLE_ACTIVITY_DUTY_EN
        ones_acc <= '0;
`endif
      end else if (cnt_en) begin
        acc      <= acc_nxt;
        sat      <= sat | acc_hit;
        cyc      <= cyc + CYC_W'(1);
`ifdef TOGGLE_ACTIVITY_DUTY_EN
        ones_acc <= ones_nxt;
`endif
      end
      if (close) begin
        win_idx <= win_idx + WIN_IDX_W'(1);
        if (!out_valid || out_ready) begin
          out_rec   <= rec_close;
          out_valid <= 1'b1;
        end else if (drop_cnt != 8'hff) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_toggles = out_rec.toggles;
  assign out_win_idx = out_rec.hdr.win_idx;
  assign out_partial = out_rec.hdr.partial;
  assign out_sat     = out_rec.hdr.sat;
`ifdef TOGGLE_ACTIVITY_DUTY_EN
  assign out_ones    = out_rec.ones;
`endif

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Bench for toggle_activity_monitor: two instances (CNT_W=8 and CNT_W=2)
// share all inputs and are checked every cycle against a window-level model.
module tb_toggle_activity_monitor;

  localparam int WIDTH  = 3;
  localparam int WINDOW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, out_ready;
  logic [2:0] sig, tmask;

  logic       va, vb, pa, pb, sa, sb;
  logic [7:0] tga, ia, ib, da, db;
  logic [1:0] tgb;
`ifdef TOGGLE_ACTIVITY_DUTY_EN
  logic [11:0] oa;
  logic [5:0]  ob;
`endif

  toggle_activity_monitor #(.WIDTH(WIDTH), .WINDOW(WINDOW), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .sig(sig),
    .out_valid(va), .out_ready(out_ready), .out_toggles(tga), .out_win_idx(ia),
    .out_partial(pa), .out_sat(sa), .drop_cnt(da)
`ifdef TOGGLE_ACTIVITY_DUTY_EN
    , .out_ones(oa)
`endif
  );

  toggle_activity_monitor #(.WIDTH(WIDTH), .WINDOW(WINDOW), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .sig(sig),
    .out_valid(vb), .out_ready(out_ready), .out_toggles(tgb), .out_win_idx(ib),
    .out_partial(pb), .out_sat(sb), .drop_cnt(db)
`ifdef TOGGLE_ACTIVITY_DUTY_EN
    , .out_ones(ob)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: true (unclamped) sums per window; clamping applied only when compared.
  int         mode, cnt, tot, ones, widx, drop, m_closed, m_part_c;
  logic [2:0] prev;
  int         m_valid, m_tot, m_ones, m_idx, m_part;

  function automatic int pop3(input logic [2:0] v);
    return (v[0] ? 1 : 0) + (v[1] ? 1 : 0) + (v[2] ? 1 : 0);
  endfunction

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mode = 0; cnt = 0; tot = 0; ones = 0; widx = 0; drop = 0; prev = '0;
      m_valid = 0; m_tot = 0; m_ones = 0; m_idx = 0; m_part = 0;
    end else begin
      m_closed = 0;
      m_part_c = 0;
      if (mode == 0) begin
        if (en) begin prev = sig; mode = 1; end
      end else if (mode == 1) begin
        if (en) begin prev = sig; mode = 2; cnt = 0; tot = 0; ones = 0; end
        else mode = 0;
      end else begin
        if (en) begin
          tot  += pop3(sig ^ prev);
          ones += pop3(sig);
          prev  = sig;
          cnt++;
          if (cnt == WINDOW) m_closed = 1;
        end else begin
          m_closed = (cnt > 0) ? 1 : 0;
          m_part_c = 1;
          mode     = 0;
        end
      end
      if (m_closed != 0) begin
        if (m_valid == 0 || out_ready) begin
          m_valid = 1; m_tot = tot; m_ones = ones; m_idx = widx; m_part = m_part_c;
        end else if (drop < 255) begin
          drop++;
        end
        widx = (widx + 1) % 256;
      end else if (m_valid != 0 && out_ready) begin
        m_valid = 0;
      end
      if (m_closed != 0 || mode == 0) begin cnt = 0; tot = 0; ones = 0; end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("a_valid",   int'(va),  m_valid);
    chk("a_toggles", int'(tga), clampi(m_tot, 255));
    chk("a_win_idx", int'(ia),  m_idx);
    chk("a_partial", int'(pa),  m_part);
    chk("a_sat",     int'(sa),  (m_tot > 255) ? 1 : 0);
    chk("a_drop",    int'(da),  drop);
    chk("b_valid",   int'(vb),  m_valid);
    chk("b_toggles", int'(tgb), clampi(m_tot, 3));
    chk("b_win_idx", int'(ib),  m_idx);
    chk("b_partial", int'(pb),  m_part);
    chk("b_sat",     int'(sb),  (m_tot > 3) ? 1 : 0);
    chk("b_drop",    int'(db),  drop);
`ifdef TOGGLE_ACTIVITY_DUTY_EN
    chk("a_ones",    int'(oa),  clampi(m_ones, 4095));
    chk("b_ones",    int'(ob),  clampi(m_ones, 63));
`endif
  endtask

  // Drive the next inputs, advance one cycle, compare on the falling edge.
  task automatic step();
    sig = sig ^ tmask;
    @(negedge clk);
    cmp_all();
  endtask

  task automatic wait_rec(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!va && n < 20);
    checks++;
    if (!va) begin
      errors++;
      $display("FAIL %s: no record within 20 cycles (got valid=%0d expected 1)", name, va);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; out_ready = 1'b1; sig = '0; tmask = 3'b101;

    // Reset held with en high and sig toggling.
    repeat (3) step();
    chk("rst_valid",   int'(va),  0);
    chk("rst_toggles", int'(tga), 0);
    chk("rst_idx",     int'(ia),  0);
    chk("rst_drop",    int'(da),  0);

    // Basic windows: one toggle per counted cycle.
    rst_n = 1'b1; tmask = 3'b010;
    wait_rec("basic0");
    chk("basic0_toggles", int'(tga), 4);
    chk("basic0_idx",     int'(ia),  0);
    chk("basic0_partial", int'(pa),  0);
    chk("basic0_b_sat",   int'(sb),  1);
    wait_rec("basic1");
    chk("basic1_toggles", int'(tga), 4);
    chk("basic1_idx",     int'(ia),  1);

    // Saturation of the narrow instance, then a clean single-toggle window.
    tmask = 3'b111;
    wait_rec("sat");
    chk("sat_b_toggles", int'(tgb), 3);
    chk("sat_b_sat",     int'(sb),  1);
    chk("sat_a_toggles", int'(tga), 12);
    tmask = 3'b001;
    step();
    tmask = 3'b000;
    wait_rec("clean");
    chk("clean_b_toggles", int'(tgb), 1);
    chk("clean_b_sat",     int'(sb),  0);
    chk("clean_idx",       int'(ia),  3);

    // Backpressure across two windows.
    tmask = 3'b010;
    step();
    out_ready = 1'b0;
    wait_rec("bp_load");
    repeat (4) step();
    chk("bp_valid", int'(va), 1);
    chk("bp_idx",   int'(ia), 4);
    chk("bp_drop",  int'(da), 1);
    out_ready = 1'b1;
    wait_rec("bp_next");
    chk("bp_next_idx", int'(ia), 6);

    // Partial window: en falls after two counted cycles.
    en = 1'b0; tmask = 3'b000;
    repeat (2) step();
    en = 1'b1; tmask = 3'b010;
    repeat (4) step();
    en = 1'b0; tmask = 3'b000;
    step();
    chk("part_valid",   int'(va),  1);
    chk("part_toggles", int'(tga), 2);
    chk("part_partial", int'(pa),  1);
    chk("part_idx",     int'(ia),  7);

    // Reset while a record is pending and stalled.
    out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("rstmid_valid", int'(va), 0);
    chk("rstmid_drop",  int'(da), 0);
    rst_n = 1'b1; en = 1'b1; tmask = 3'b010;
    wait_rec("rst2_rec");
    chk("rst2_idx", int'(ia), 0);
    rst_n = 1'b0;
    step();
    chk("rst2_valid", int'(va), 0);
    chk("rst2_drop",  int'(da), 0);
    rst_n = 1'b1; out_ready = 1'b1;

    // Glitch pattern: {a,c} counts 0..3 every 3 cycles, b pulses one cycle.
    for (int k = 0; k < 48; k++) begin
      logic [1:0] ac;
      logic [2:0] want;
      ac    = 2'((k / 3) % 4);
      want  = {ac[1], (k % 3 == 0), ac[0]};
      tmask = want ^ sig;
      step();
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom % 16) != 0;
      out_ready = ($urandom % 4) != 0;
      rst_n     = ($urandom % 400) != 0;
      tmask     = 3'($urandom % 8);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/toggle_activity_monitor.md
Name: toggle_activity_monitor

Overview:
- Receive-side counterpart to the stimulus/glitch generator blocks: watches a WIDTH-bit signal bus and measures its switching activity.
- Counts bit toggles per fixed window of clock cycles and emits one record per window over a valid/ready interface.
- Used on-chip and in benches to cross-check the toggle counts trace2power derives from VCD dumps.

Parameters:
- WIDTH, 3, number of monitored bits.
- WINDOW, 16, counted cycles per window (>=2).
- CNT_W, 8, width of the toggle accumulator and output count.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  monitoring enable.
- sig  input  WIDTH  monitored bus, already synchronous to clk.
- out_valid  output  1  record available.
- out_ready  input  1  consumer accepts record.
- out_toggles  output  CNT_W  toggles in the window, saturating.
- out_win_idx  output  8  window sequence number; wraps 255->0.
- out_partial  output  1  window cut short by en falling.
- out_sat  output  1  accumulator saturated this window.
- drop_cnt  output  8  records lost to backpressure; saturates at 255.

Behaviour:
- Reset (rst_n=0 at an edge):
  - All outputs go to 0, FSM to IDLE, accumulators cleared, out_win_idx counter cleared.
  - Applies mid-window and mid-handshake; a pending record is discarded without counting a drop.
- FSM:
  - IDLE: leave when en=1, capturing sig into prev and going to ARM. No toggles are counted on the capture cycle.
  - ARM: one cycle. Captures sig into prev, then goes to RUN with cyc=0.
  - RUN: every cycle, acc += popcount(sig ^ prev) and prev <= sig.
    - acc saturates at 2^CNT_W-1; the sat flag is set on saturation.
    - cyc increments; when cyc==WINDOW-1, the record is closed, cyc goes to 0, and RUN continues.
    - Consecutive windows are gapless.
  - RUN with en=0: this cycle is not counted. If cyc>0, a record closes with partial=1. Go to IDLE.
  - IDLE/ARM with en=0: go to (or stay in) IDLE; no record.
- Record close:
  - The output register loads {acc_final, win_idx, partial, sat} on the closing edge, so out_valid rises the cycle after the last counted cycle.
  - acc, sat, and cyc are cleared for the next window.
  - win_idx increments on every closed record, including dropped ones.
- Handshake:
  - out_valid stays high and the data stays stable until out_valid&&out_ready at an edge.
  - A transfer and a new close on the same edge load the new record, with no gap.
  - A close while out_valid=1 and out_ready=0 drops the new record, keeps the old one, and increments drop_cnt (saturating).
- Arithmetic: popcount is up to WIDTH per cycle. The acc add is done at CNT_W+1 bits and then clamped.

Optional Feature:
- Macro: TOGGLE_ACTIVITY_DUTY_EN.
- When defined, adds output out_ones [CNT_W+4-1:0]: the sum over counted cycles of popcount(sig), i.e. per-window static-probability numerator.
  - Saturates independently.
  - Loaded and held with the record.
  - Reset to 0.
- When undefined: no port and no logic; the record is unchanged.

Decomposition:
- Shared package toggle_mon_pkg:
  - state enum {IDLE, ARM, RUN}.
  - Record struct (toggles, win_idx, partial, sat [, ones]).
  - Saturating-add function.
  - Constant WIN_IDX_W=8.
- Sub-module popcount (param WIDTH, combinational) is instantiated once for toggles and once more under TOGGLE_ACTIVITY_DUTY_EN.

Test Plan (WIDTH=3, WINDOW=4, CNT_W=8 unless stated):
- Reset check: hold rst_n=0 for 3 cycles with en=1 and sig toggling -> all outputs 0, out_valid=0.
- Basic window: en=1, sig[1] inverts every cycle, out_ready=1 -> first record has out_toggles=4, win_idx=0, partial=0. Next record: toggles=4, win_idx=1.
- Glitch pattern: sig={a,b,c} with {a,c} stepping through 0..3 every 3 cycles and b pulsing 1 cycle high -> per-window toggle counts match the VCD-derived popcount sum exactly.
- Backpressure: out_ready=0 for 2 windows -> record win_idx=0 held unchanged, drop_cnt=1. Then out_ready=1 -> win_idx=0 accepted, and the next record is win_idx=2.
- Saturation: CNT_W=2, sig inverts all 3 bits every cycle -> toggles=3, sat=1. The next window starts clean.
- Partial/reset mid-op: en drops after 2 RUN cycles with 1 toggle each -> toggles=2, partial=1. A separate run asserts rst_n=0 while out_valid=1 -> out_valid=0 and drop_cnt unchanged at 0.
